simple_if_to_axil: RTL and testbench

- AXI-Lite initiator (manager) bridge; the master-side counterpart of the axil_to_simple_if responder used in soc_ctrl.
- Converts a simple single-beat request interface into AXI-Lite transactions.
- Used by a boot/debug sequencer or test controller to program soc_ctrl registers over the ref_clk_i domain.
- Independent write and read engines; one outstanding transaction per direction.

---
 rtl/dual_helix_pkg.sv | 54 +++++
 rtl/simple_if_to_axil.sv | 117 +++++++++++
 tb/tb_simple_if_to_axil.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dual_helix_pkg.sv
// dual_helix_pkg: shared AXI-Lite types, response encodings and bridge FSM states.
package dual_helix_pkg;

    localparam int AXIL_ADDR_WIDTH = 32;
    localparam int AXIL_DATA_WIDTH = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [AXIL_ADDR_WIDTH-1:0] addr;
        logic [2:0]                 prot;
    } dhs_axil_ax_t;

    typedef struct packed {
        logic [AXIL_DATA_WIDTH-1:0]   data;
        logic [AXIL_DATA_WIDTH/8-1:0] strb;
    } dhs_axil_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } dhs_axil_b_t;

    typedef struct packed {
        logic [AXIL_DATA_WIDTH-1:0] data;
        logic [1:0]                 resp;
    } dhs_axil_r_t;

    typedef struct packed {
        dhs_axil_ax_t aw;
        logic         aw_valid;
        dhs_axil_w_t  w;
        logic         w_valid;
        logic         b_ready;
        dhs_axil_ax_t ar;
        logic         ar_valid;
        logic         r_ready;
    } dhs_axil_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        logic        b_valid;
        dhs_axil_b_t b;
        logic        ar_ready;
        logic        r_valid;
        dhs_axil_r_t r;
    } dhs_axil_resp_t;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2} axil_mst_wr_state_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} axil_mst_rd_state_e;

endpackage

// File: rtl/simple_if_to_axil.sv
// simple_if_to_axil: single-beat request interface to AXI-Lite manager bridge,
// with independent write and read engines, one outstanding transaction each.
module simple_if_to_axil
    import dual_helix_pkg::*;
#(
    parameter type req_t      = dhs_axil_req_t,
    parameter type resp_t     = dhs_axil_resp_t,
    parameter int  ADDR_WIDTH = 32,
    parameter int  DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    arst_ni,
    input  logic                    wr_req_i,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
    output logic                    wr_ready_o,
    output logic                    wr_done_o,
    output logic [1:0]              wr_resp_o,
    input  logic                    rd_req_i,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic                    rd_ready_o,
    output logic                    rd_done_o,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic [1:0]              rd_resp_o,
    output req_t                    axil_req_o,
    input  resp_t                   axil_resp_i
);

    axil_mst_wr_state_e      wr_state;
    axil_mst_rd_state_e      rd_state;
    logic                    aw_pend, w_pend;
    logic [ADDR_WIDTH-1:0]   aw_addr, ar_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;

    assign wr_ready_o = wr_state == W_IDLE;
    assign rd_ready_o = rd_state == R_IDLE;

    // AW and W handshake independently; leave W_REQ once neither is still pending
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_state  <= W_IDLE;
            aw_pend   <= 1'b0;
            w_pend    <= 1'b0;
            aw_addr   <= '0;
            w_data    <= '0;
            w_strb    <= '0;
            wr_done_o <= 1'b0;
            wr_resp_o <= AXI_RESP_OKAY;
        end else begin
            wr_done_o <= 1'b0;
            case (wr_state)
                W_IDLE: if (wr_req_i) begin
                    aw_addr  <= wr_addr_i;
                    w_data   <= wr_data_i;
                    w_strb   <= wr_strb_i;
                    aw_pend  <= 1'b1;
                    w_pend   <= 1'b1;
                    wr_state <= W_REQ;
                end
                W_REQ: begin
                    aw_pend <= aw_pend & ~axil_resp_i.aw_ready;
                    w_pend  <= w_pend & ~axil_resp_i.w_ready;
                    if ((!aw_pend || axil_resp_i.aw_ready) && (!w_pend || axil_resp_i.w_ready))
                        wr_state <= W_RESP;
                end
                W_RESP: if (axil_resp_i.b_valid) begin
                    wr_resp_o <= axil_resp_i.b.resp;
                    wr_done_o <= 1'b1;
                    wr_state  <= W_IDLE;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rd_state  <= R_IDLE;
            ar_addr   <= '0;
            rd_done_o <= 1'b0;
            rd_data_o <= '0;
            rd_resp_o <= AXI_RESP_OKAY;
        end else begin
            rd_done_o <= 1'b0;
            case (rd_state)
                R_IDLE: if (rd_req_i) begin
                    ar_addr  <= rd_addr_i;
                    rd_state <= R_ADDR;
                end
                R_ADDR: if (axil_resp_i.ar_ready) rd_state <= R_DATA;
                R_DATA: if (axil_resp_i.r_valid) begin
                    rd_data_o <= axil_resp_i.r.data;
                    rd_resp_o <= axil_resp_i.r.resp;
                    rd_done_o <= 1'b1;
                    rd_state  <= R_IDLE;
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        axil_req_o          = '0;
        axil_req_o.aw.addr  = aw_addr;
        axil_req_o.aw_valid = wr_state == W_REQ && aw_pend;
        axil_req_o.w.data   = w_data;
        axil_req_o.w.strb   = w_strb;
        axil_req_o.w_valid  = wr_state == W_REQ && w_pend;
        axil_req_o.b_ready  = wr_state == W_RESP;
        axil_req_o.ar.addr  = ar_addr;
        axil_req_o.ar_valid = rd_state == R_ADDR;
        axil_req_o.r_ready  = rd_state == R_DATA;
    end

endmodule

// File: tb/tb_simple_if_to_axil.sv
// tb_simple_if_to_axil: directed self-checking bench; each task drives the fabric
// side by hand and checks cycle-exact behaviour against hand-computed values.
module tb_simple_if_to_axil;
    import dual_helix_pkg::*;

    logic           clk_i = 1'b0;
    logic           arst_ni;
    logic           wr_req_i, rd_req_i;
    logic [31:0]    wr_addr_i, wr_data_i, rd_addr_i;
    logic [3:0]     wr_strb_i;
    logic           wr_ready_o, wr_done_o, rd_ready_o, rd_done_o;
    logic [1:0]     wr_resp_o, rd_resp_o;
    logic [31:0]    rd_data_o;
    dhs_axil_req_t  axil_req;
    dhs_axil_resp_t axil_resp;
    int             checks = 0;
    int             errors = 0;

    always #5 clk_i = ~clk_i;

    simple_if_to_axil dut (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i),
        .wr_ready_o(wr_ready_o), .wr_done_o(wr_done_o), .wr_resp_o(wr_resp_o),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i),
        .rd_ready_o(rd_ready_o), .rd_done_o(rd_done_o), .rd_data_o(rd_data_o), .rd_resp_o(rd_resp_o),
        .axil_req_o(axil_req), .axil_resp_i(axil_resp)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks += 6;
        if (axil_req !== '0) begin errors++; $display("FAIL reset_req: got %h expected 0", axil_req); end
        if (wr_ready_o !== 1'b1 || rd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got wr=%b rd=%b expected 1 1", wr_ready_o, rd_ready_o); end
        if (wr_done_o !== 1'b0 || rd_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got wr=%b rd=%b expected 0 0", wr_done_o, rd_done_o); end
        if (wr_resp_o !== 2'b00) begin errors++; $display("FAIL reset_wr_resp: got %b expected 00", wr_resp_o); end
        if (rd_resp_o !== 2'b00) begin errors++; $display("FAIL reset_rd_resp: got %b expected 00", rd_resp_o); end
        if (rd_data_o !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data_o); end
        @(negedge clk_i);
        arst_ni = 1'b1;
    endtask

    task automatic test_write_basic();
        axil_resp = '0;
        axil_resp.aw_ready = 1'b1;
        axil_resp.w_ready  = 1'b1;
        axil_resp.b_valid  = 1'b1;
        axil_resp.b.resp   = AXI_RESP_OKAY;
        step();
        wr_req_i = 1'b1; wr_addr_i = 32'h0000_0010; wr_data_i = 32'hDEAD_BEEF; wr_strb_i = 4'hF;
        step();
        wr_req_i = 1'b0;
        checks += 5;
        if (axil_req.aw_valid !== 1'b1 || axil_req.w_valid !== 1'b1) begin errors++; $display("FAIL wb_c1_valid: got aw=%b w=%b expected 1 1", axil_req.aw_valid, axil_req.w_valid); end
        if (axil_req.aw.addr !== 32'h10) begin errors++; $display("FAIL wb_addr: got %h expected 00000010", axil_req.aw.addr); end
        if (axil_req.w.data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wb_data: got %h expected deadbeef", axil_req.w.data); end
        if (axil_req.w.strb !== 4'hF) begin errors++; $display("FAIL wb_strb: got %h expected f", axil_req.w.strb); end
        if (axil_req.b_ready !== 1'b0 || wr_ready_o !== 1'b0) begin errors++; $display("FAIL wb_c1_busy: got b_ready=%b wr_ready=%b expected 0 0", axil_req.b_ready, wr_ready_o); end
        step();
        checks += 2;
        if (axil_req.b_ready !== 1'b1) begin errors++; $display("FAIL wb_c2_bready: got %b expected 1", axil_req.b_ready); end
        if (axil_req.aw_valid !== 1'b0 || axil_req.w_valid !== 1'b0) begin errors++; $display("FAIL wb_c2_valid: got aw=%b w=%b expected 0 0", axil_req.aw_valid, axil_req.w_valid); end
        step();
        checks += 2;
        if (wr_done_o !== 1'b1 || wr_resp_o !== 2'b00) begin errors++; $display("FAIL wb_c3_done: got done=%b resp=%b expected 1 00", wr_done_o, wr_resp_o); end
        if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL wb_c3_ready: got %b expected 1", wr_ready_o); end
        step();
        checks++;
        if (wr_done_o !== 1'b0) begin errors++; $display("FAIL wb_c4_done: got %b expected 0", wr_done_o); end
    endtask

    task automatic test_write_skew();
        int aw_n = 0, w_n = 0, b_n = 0, d_n = 0, bad = 0;
        axil_resp = '0;
        axil_resp.w_ready = 1'b1;
        axil_resp.b_valid = 1'b1;
        axil_resp.b.resp  = AXI_RESP_DECERR;
        step();
        wr_req_i = 1'b1; wr_addr_i = 32'h20; wr_data_i = 32'hA5A5_A5A5; wr_strb_i = 4'h3;
        for (int c = 1; c <= 10; c++) begin
            step();
            wr_req_i = 1'b0;
            axil_resp.aw_ready = c >= 4;
            aw_n += int'(axil_req.aw_valid);
            w_n  += int'(axil_req.w_valid);
            b_n  += int'(axil_req.b_ready);
            d_n  += int'(wr_done_o);
            if (axil_req.aw_valid && axil_req.aw.addr !== 32'h20) bad++;
        end
        checks += 6;
        if (aw_n != 4) begin errors++; $display("FAIL skew_aw_cycles: got %0d expected 4", aw_n); end
        if (w_n != 1) begin errors++; $display("FAIL skew_w_cycles: got %0d expected 1", w_n); end
        if (bad != 0) begin errors++; $display("FAIL skew_addr_stable: got %0d unstable cycles expected 0", bad); end
        if (b_n != 1) begin errors++; $display("FAIL skew_b_count: got %0d expected 1", b_n); end
        if (d_n != 1) begin errors++; $display("FAIL skew_done_count: got %0d expected 1", d_n); end
        if (wr_resp_o !== AXI_RESP_DECERR) begin errors++; $display("FAIL skew_resp: got %b expected 11", wr_resp_o); end
    endtask

    task automatic test_read_delay();
        int ar_n = 0, r_n = 0, busy_bad = 0, d_n = 0, d_c = 0, bad = 0;
        axil_resp = '0;
        axil_resp.r.data = 32'h1234_5678;
        axil_resp.r.resp = AXI_RESP_SLVERR;
        step();
        rd_req_i = 1'b1; rd_addr_i = 32'h24;
        for (int c = 1; c <= 12; c++) begin
            step();
            rd_req_i = 1'b0;
            axil_resp.ar_ready = c == 3;
            axil_resp.r_valid  = c == 8;
            ar_n += int'(axil_req.ar_valid);
            r_n  += int'(axil_req.r_ready);
            if (c <= 8 && rd_ready_o) busy_bad++;
            if (axil_req.ar_valid && axil_req.ar.addr !== 32'h24) bad++;
            if (rd_done_o) begin d_n++; d_c = c; end
        end
        checks += 8;
        if (ar_n != 3) begin errors++; $display("FAIL rd_ar_cycles: got %0d expected 3", ar_n); end
        if (bad != 0) begin errors++; $display("FAIL rd_addr: got %0d bad cycles expected 0", bad); end
        if (r_n != 5) begin errors++; $display("FAIL rd_rready_cycles: got %0d expected 5", r_n); end
        if (busy_bad != 0) begin errors++; $display("FAIL rd_ready_busy: got %0d ready cycles expected 0", busy_bad); end
        if (d_n != 1) begin errors++; $display("FAIL rd_done_count: got %0d expected 1", d_n); end
        if (d_c != 9) begin errors++; $display("FAIL rd_done_cycle: got %0d expected 9", d_c); end
        if (rd_data_o !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h expected 12345678", rd_data_o); end
        if (rd_resp_o !== AXI_RESP_SLVERR) begin errors++; $display("FAIL rd_resp: got %b expected 10", rd_resp_o); end
    endtask

    task automatic test_concurrent();
        axil_resp = '0;
        axil_resp.aw_ready = 1'b1; axil_resp.w_ready = 1'b1; axil_resp.b_valid = 1'b1;
        axil_resp.ar_ready = 1'b1; axil_resp.r_valid = 1'b1;
        axil_resp.r.data = 32'hCAFE_F00D; axil_resp.r.resp = AXI_RESP_OKAY;
        step();
        wr_req_i = 1'b1; wr_addr_i = 32'h30; wr_data_i = 32'h3030_3030; wr_strb_i = 4'hF;
        rd_req_i = 1'b1; rd_addr_i = 32'h34;
        step();
        rd_req_i = 1'b0;
        wr_addr_i = 32'h40; wr_data_i = 32'h4040_4040;
        checks += 3;
        if (axil_req.aw_valid !== 1'b1 || axil_req.ar_valid !== 1'b1) begin errors++; $display("FAIL cc_c1_valid: got aw=%b ar=%b expected 1 1", axil_req.aw_valid, axil_req.ar_valid); end
        if (axil_req.aw.addr !== 32'h30) begin errors++; $display("FAIL cc_aw_addr: got %h expected 00000030", axil_req.aw.addr); end
        if (axil_req.ar.addr !== 32'h34) begin errors++; $display("FAIL cc_ar_addr: got %h expected 00000034", axil_req.ar.addr); end
        step();
        checks += 2;
        if (axil_req.b_ready !== 1'b1 || axil_req.r_ready !== 1'b1) begin errors++; $display("FAIL cc_c2_ready: got b=%b r=%b expected 1 1", axil_req.b_ready, axil_req.r_ready); end
        if (axil_req.aw_valid !== 1'b0 || axil_req.w.data !== 32'h3030_3030) begin errors++; $display("FAIL cc_busy_ignored: got aw_valid=%b data=%h expected 0 30303030", axil_req.aw_valid, axil_req.w.data); end
        step();
        checks += 3;
        if (wr_done_o !== 1'b1 || rd_done_o !== 1'b1) begin errors++; $display("FAIL cc_done: got wr=%b rd=%b expected 1 1", wr_done_o, rd_done_o); end
        if (rd_data_o !== 32'hCAFE_F00D || rd_resp_o !== 2'b00) begin errors++; $display("FAIL cc_rd_data: got %h/%b expected cafef00d/00", rd_data_o, rd_resp_o); end
        if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL cc_wr_ready: got %b expected 1", wr_ready_o); end
        step();
        wr_req_i = 1'b0;
        checks += 2;
        if (axil_req.aw_valid !== 1'b1 || axil_req.aw.addr !== 32'h40 || axil_req.w.data !== 32'h4040_4040) begin errors++; $display("FAIL cc_second_wr: got valid=%b addr=%h data=%h expected 1 00000040 40404040", axil_req.aw_valid, axil_req.aw.addr, axil_req.w.data); end
        if (rd_done_o !== 1'b0 || axil_req.ar_valid !== 1'b0) begin errors++; $display("FAIL cc_rd_quiet: got done=%b ar_valid=%b expected 0 0", rd_done_o, axil_req.ar_valid); end
        step();
        step();
        checks++;
        if (wr_done_o !== 1'b1) begin errors++; $display("FAIL cc_second_done: got %b expected 1", wr_done_o); end
    endtask

    task automatic test_back_to_back();
        step();
        wr_req_i = 1'b1; wr_addr_i = 32'h50; wr_data_i = 32'h1; wr_strb_i = 4'h1;
        step();
        wr_req_i = 1'b0;
        step();
        step();
        checks++;
        if (wr_done_o !== 1'b1 || wr_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_done: got done=%b ready=%b expected 1 1", wr_done_o, wr_ready_o); end
        wr_req_i = 1'b1; wr_addr_i = 32'h54; wr_data_i = 32'h2; wr_strb_i = 4'h2;
        step();
        wr_req_i = 1'b0;
        checks += 2;
        if (axil_req.aw_valid !== 1'b1 || axil_req.aw.addr !== 32'h54) begin errors++; $display("FAIL b2b_aw: got valid=%b addr=%h expected 1 00000054", axil_req.aw_valid, axil_req.aw.addr); end
        if (axil_req.w.data !== 32'h2 || axil_req.w.strb !== 4'h2) begin errors++; $display("FAIL b2b_w: got data=%h strb=%h expected 00000002 2", axil_req.w.data, axil_req.w.strb); end
        step();
        step();
        checks++;
        if (wr_done_o !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b expected 1", wr_done_o); end
    endtask

    task automatic test_reset_mid();
        axil_resp = '0;
        axil_resp.w_ready = 1'b1; axil_resp.ar_ready = 1'b1;
        step();
        wr_req_i = 1'b1; wr_addr_i = 32'h60; wr_data_i = 32'h6; wr_strb_i = 4'hF;
        rd_req_i = 1'b1; rd_addr_i = 32'h64;
        step();
        wr_req_i = 1'b0; rd_req_i = 1'b0;
        step();
        checks++;
        if (axil_req.aw_valid !== 1'b1 || axil_req.r_ready !== 1'b1) begin errors++; $display("FAIL mid_pre: got aw_valid=%b r_ready=%b expected 1 1", axil_req.aw_valid, axil_req.r_ready); end
        #1;
        arst_ni = 1'b0;
        #1;
        checks += 4;
        if (axil_req !== '0) begin errors++; $display("FAIL mid_req: got %h expected 0", axil_req); end
        if (wr_ready_o !== 1'b1 || rd_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ready: got wr=%b rd=%b expected 1 1", wr_ready_o, rd_ready_o); end
        if (rd_data_o !== 32'h0 || rd_resp_o !== 2'b00 || wr_resp_o !== 2'b00) begin errors++; $display("FAIL mid_stored: got data=%h rresp=%b wresp=%b expected 0 00 00", rd_data_o, rd_resp_o, wr_resp_o); end
        if (wr_done_o !== 1'b0 || rd_done_o !== 1'b0) begin errors++; $display("FAIL mid_done: got wr=%b rd=%b expected 0 0", wr_done_o, rd_done_o); end
        @(negedge clk_i);
        arst_ni = 1'b1;
        step();
        checks++;
        if (axil_req.aw_valid !== 1'b0 || axil_req.r_ready !== 1'b0 || wr_ready_o !== 1'b1) begin errors++; $display("FAIL mid_post: got aw_valid=%b r_ready=%b wr_ready=%b expected 0 0 1", axil_req.aw_valid, axil_req.r_ready, wr_ready_o); end
    endtask

    initial begin
        arst_ni = 1'b0;
        wr_req_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; wr_strb_i = '0;
        rd_req_i = 1'b0; rd_addr_i = '0;
        axil_resp = '0;
        test_reset();
        test_write_basic();
        test_write_skew();
        test_read_delay();
        test_concurrent();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
